// File: rtl/par8_pkg.sv
// Shared definitions for the 8-bit parallel bus controller: opcodes, FSM
// state encodings and the layout of the STATUS byte.
package par8_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_LEN    = 3'd1,
    ST_WRITE_DATA = 3'd2,
    ST_READ_DATA  = 3'd3,
    ST_STATUS     = 3'd4
  } state_e;

  localparam int STAT_ERR_BIT = 7;
  localparam int STAT_OP_MSB  = 2;
  localparam int STAT_OP_LSB  = 0;

  function automatic logic [7:0] status_byte(input logic err, input logic [7:0] op);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_ERR_BIT] = err;
    b[STAT_OP_MSB:STAT_OP_LSB] = op[2:0];
    return b;
  endfunction

endpackage

// File: rtl/par8_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe, followed by a one-cycle
// pulse on each synchronised rising edge.
module par8_sync_edge (
  input  logic clk_100mhz,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/par8_bus_ctrl.sv
// Transaction controller for the 8-bit host parallel bus: decodes an opcode and
// length header, then runs a write burst, a read burst or a status read.
module par8_bus_ctrl
  import par8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  STALL_BYTE     = 8'hEE
) (
  input  logic       clk_100mhz,
  input  logic       reset_n,
  input  logic       bus_clk,
  input  logic       bus_rnw,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       wr_last,
  input  logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       rd_ack,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Handshake: wr_valid is a one-cycle strobe per payload byte with no back
  // pressure; rd_ready qualifies rd_data and rd_ack pulses once per consumed byte.
  logic            bus_ev;
  logic            rnw_m, rnw_s;
  logic [7:0]      data_m, data_s;
  state_e          state;
  logic [7:0]      cur_op;
  logic [8:0]      rem;
  logic [TO_W-1:0] to_cnt;

  par8_sync_edge u_clk_sync (
    .clk_100mhz (clk_100mhz),
    .reset_n    (reset_n),
    .async_in   (bus_clk),
    .rise       (bus_ev)
  );

  // Data and direction are held stable around the strobe, so plain two-flop
  // synchronisers line up with the edge pulse.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      rnw_m  <= 1'b0;
      rnw_s  <= 1'b0;
      data_m <= 8'h00;
      data_s <= 8'h00;
    end else begin
      rnw_m  <= bus_rnw;
      rnw_s  <= rnw_m;
      data_m <= bus_data_in;
      data_s <= data_m;
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cur_op       <= 8'h00;
      rem          <= 9'd0;
      to_cnt       <= '0;
      err          <= 1'b0;
      wr_data      <= 8'h00;
      wr_valid     <= 1'b0;
      wr_last      <= 1'b0;
      rd_ack       <= 1'b0;
      bus_data_out <= 8'h00;
      bus_data_oe  <= 1'b0;
    end else begin
      wr_valid    <= 1'b0;
      wr_last     <= 1'b0;
      rd_ack      <= 1'b0;
      bus_data_oe <= rnw_s && (state == ST_READ_DATA || state == ST_STATUS);
      case (state)
        ST_READ_DATA: bus_data_out <= rd_ready ? rd_data : STALL_BYTE;
        ST_STATUS:    bus_data_out <= status_byte(err, cur_op);
        default:      bus_data_out <= 8'h00;
      endcase

      if (bus_ev) begin
        // An event always beats a coincident timeout expiry.
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rnw_s) begin
              err <= 1'b1;
            end else begin
              case (data_s)
                OP_NOP: cur_op <= data_s;
                OP_WRITE, OP_READ: begin
                  cur_op <= data_s;
                  state  <= ST_GET_LEN;
                end
                OP_STATUS: state <= ST_STATUS;
                default:   err <= 1'b1;
              endcase
            end
          end
          ST_GET_LEN: begin
            if (rnw_s) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              rem   <= (data_s == 8'h00) ? 9'd256 : {1'b0, data_s};
              state <= (cur_op == OP_READ) ? ST_READ_DATA : ST_WRITE_DATA;
            end
          end
          ST_WRITE_DATA: begin
            if (rnw_s) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              wr_valid <= 1'b1;
              wr_data  <= data_s;
              rem      <= rem - 1'b1;
              if (rem == 9'd1) begin
                wr_last <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end
          ST_READ_DATA: begin
            if (!rnw_s) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              if (rd_ready) rd_ack <= 1'b1;
              else          err    <= 1'b1;
              rem <= rem - 1'b1;
              if (rem == 9'd1) state <= ST_IDLE;
            end
          end
          ST_STATUS: begin
            err   <= rnw_s ? 1'b0 : 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_LAST) begin
          err    <= 1'b1;
          state  <= ST_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_par8_bus_ctrl.sv
// Directed bench for par8_bus_ctrl: drives host bus cycles and checks the
// downstream strobes, read data, error flag and timeout behaviour.
module tb_par8_bus_ctrl;

  localparam int TO = 300;

  logic       clk_100mhz = 1'b0;
  logic       reset_n = 1'b0;
  logic       bus_clk = 1'b0;
  logic       bus_rnw = 1'b0;
  logic [7:0] bus_data_in = 8'h00;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_last;
  logic [7:0] rd_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       rd_ack;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wv_cnt   = 0;
  int wl_cnt   = 0;
  int ack_cnt  = 0;
  logic [8:0] exp_q[$];
  logic [7:0] rb;

  par8_bus_ctrl #(.TIMEOUT_CYCLES(TO), .STALL_BYTE(8'hEE)) dut (
    .clk_100mhz   (clk_100mhz),
    .reset_n      (reset_n),
    .bus_clk      (bus_clk),
    .bus_rnw      (bus_rnw),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_last      (wr_last),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .rd_ack       (rd_ack),
    .busy         (busy),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of exp_q ({last, data}).
  always @(negedge clk_100mhz) begin
    logic [8:0] e;
    if (wr_valid) begin
      wv_cnt++;
      if (wr_last) wl_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL wr_unexpected: observed 0x%0h expected no strobe", {wr_last, wr_data});
      end else begin
        e = exp_q.pop_front();
        check("wr_beat", {23'b0, wr_last, wr_data}, {23'b0, e});
      end
    end
    if (wr_last && !wr_valid) begin
      n_checks++;
      n_fail++;
      $error("FAIL wr_last_alone: observed 1 expected 0");
    end
    if (rd_ack) ack_cnt++;
  end

  // Driver tasks; all inputs change on the falling clock edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic host_write(input logic [7:0] b);
    bus_rnw = 1'b0;
    bus_data_in = b;
    tick(6);
    bus_clk = 1'b1;
    tick(6);
    bus_clk = 1'b0;
    tick(6);
  endtask

  task automatic host_read(output logic [7:0] b);
    bus_rnw = 1'b1;
    tick(8);
    b = bus_data_out;
    check("read_oe", {31'b0, bus_data_oe}, 32'd1);
    bus_clk = 1'b1;
    tick(6);
    bus_clk = 1'b0;
    tick(6);
  endtask

  initial begin
    tick(5);
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_err",   {31'b0, err}, 0);
    check("rst_wv",    {31'b0, wr_valid}, 0);
    check("rst_oe",    {31'b0, bus_data_oe}, 0);
    check("rst_dout",  {24'b0, bus_data_out}, 0);
    check("rst_state", {29'b0, dbg_state}, 0);
    reset_n = 1'b1;
    tick(4);

    // WRITE, L = 4
    host_write(8'h01);
    check("oe_low_on_write", {31'b0, bus_data_oe}, 0);
    host_write(8'h04);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), 8'h10 + 8'(i)});
      host_write(8'h10 + 8'(i));
    end
    tick(4);
    check("w4_cnt",  wv_cnt, 4);
    check("w4_last", wl_cnt, 1);
    check("w4_busy", {31'b0, busy}, 0);

    // WRITE, L = 0 (256 bytes)
    host_write(8'h01);
    host_write(8'h00);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({(i == 255), i[7:0]});
      host_write(i[7:0]);
    end
    tick(4);
    check("w256_cnt",  wv_cnt, 260);
    check("w256_last", wl_cnt, 2);
    check("w256_err",  {31'b0, err}, 0);
    check("w256_busy", {31'b0, busy}, 0);

    // READ, L = 2, data ready
    rd_ready = 1'b1;
    rd_data = 8'hA5;
    host_write(8'h02);
    host_write(8'h02);
    host_read(rb);
    check("rd0_data", {24'b0, rb}, 32'hA5);
    rd_data = 8'h5A;
    host_read(rb);
    check("rd1_data", {24'b0, rb}, 32'h5A);
    tick(4);
    check("rd_acks",   ack_cnt, 2);
    check("rd_err",    {31'b0, err}, 0);
    check("rd_oe_end", {31'b0, bus_data_oe}, 0);
    check("rd_busy",   {31'b0, busy}, 0);

    // READ, L = 1, stalled source, then STATUS
    rd_ready = 1'b0;
    host_write(8'h02);
    host_write(8'h01);
    host_read(rb);
    check("stall_data", {24'b0, rb}, 32'hEE);
    tick(4);
    check("stall_ack", ack_cnt, 2);
    check("stall_err", {31'b0, err}, 1);
    host_write(8'h03);
    check("status_state", {29'b0, dbg_state}, 4);
    host_read(rb);
    check("status_byte", {24'b0, rb}, 32'h82);
    tick(4);
    check("status_clr", {31'b0, err}, 0);

    // Illegal opcode, clear, then truncated WRITE that times out
    host_write(8'h7F);
    check("bad_op_err",  {31'b0, err}, 1);
    check("bad_op_busy", {31'b0, busy}, 0);
    host_write(8'h03);
    host_read(rb);
    check("status2_byte", {24'b0, rb}, 32'h82);
    tick(4);
    check("status2_clr", {31'b0, err}, 0);
    host_write(8'h01);
    host_write(8'h03);
    exp_q.push_back({1'b0, 8'h44});
    host_write(8'h44);
    tick(TO / 2);
    check("to_pending_busy", {31'b0, busy}, 1);
    check("to_pending_err",  {31'b0, err}, 0);
    tick(TO);
    check("to_busy",  {31'b0, busy}, 0);
    check("to_err",   {31'b0, err}, 1);
    check("to_state", {29'b0, dbg_state}, 0);
    check("to_cnt",   wv_cnt, 261);
    check("to_last",  wl_cnt, 2);

    // Reset during a WRITE of 5 after 2 bytes
    host_write(8'h01);
    host_write(8'h05);
    exp_q.push_back({1'b0, 8'hB0});
    host_write(8'hB0);
    exp_q.push_back({1'b0, 8'hB1});
    host_write(8'hB1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'b0, busy}, 0);
    check("mid_rst_err",   {31'b0, err}, 0);
    check("mid_rst_state", {29'b0, dbg_state}, 0);
    check("mid_rst_wv",    {31'b0, wr_valid}, 0);
    check("mid_rst_oe",    {31'b0, bus_data_oe}, 0);
    tick(4);
    reset_n = 1'b1;
    tick(4);
    host_write(8'h01);
    host_write(8'h01);
    exp_q.push_back({1'b1, 8'hC7});
    host_write(8'hC7);
    tick(4);
    check("post_rst_cnt",  wv_cnt, 264);
    check("post_rst_last", wl_cnt, 3);
    check("post_rst_err",  {31'b0, err}, 0);
    check("post_rst_busy", {31'b0, busy}, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
